// File: rtl/scoreboard_pkg.sv
// ============================================================================
// Module   : scoreboard_pkg
// Purpose  : Shared defaults and FSM state encoding for the BCD-to-binary block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package scoreboard_pkg;

  localparam int DIGITS_DEF = 3;
  localparam int BIN_W_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_to_binary_if.sv
// ============================================================================
// Module   : bcd_to_binary_if
// Purpose  : Start/done handshake and data bus of the BCD-to-binary converter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_to_binary_if
  import scoreboard_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) ();

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  ready;
  logic                  done;
  logic [BIN_W-1:0]      binary;
  logic                  error;

  modport master (
    output start,
    output bcd_in,
    input  ready,
    input  done,
    input  binary,
    input  error
  );

  modport slave (
    input  start,
    input  bcd_in,
    output ready,
    output done,
    output binary,
    output error
  );

endinterface

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// ============================================================================
// Module   : bcd_digit_adjust
// Purpose  : Reverse double-dabble correction: subtract 3 from a nibble >= 8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adjust (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd8) ? (nib_i - 4'd3) : nib_i;

endmodule

`default_nettype wire

// File: rtl/bcd_to_binary.sv
// ============================================================================
// Module   : bcd_to_binary
// Purpose  : Sequential packed-BCD to binary converter (reverse double-dabble).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_binary
  import scoreboard_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  bcd_to_binary_if.slave  bus
);

  localparam int c_work_w = 4*DIGITS + BIN_W;
  localparam int c_cnt_w  = $clog2(BIN_W + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BIN_W - 1);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  state_t                state_q, state_d;
  logic [c_work_w-1:0]   work_q, work_d;
  logic [c_cnt_w-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0]      binary_q, binary_d;
  logic                  error_q, error_d;

  logic [c_work_w-1:0]   w_shifted;
  logic [c_work_w-1:0]   w_adjusted;
  logic [DIGITS-1:0]     w_nib_bad;
  logic                  w_any_bad;

  // Working register is {BCD digits, binary field}; BCD LSB falls into binary MSB.
  assign w_shifted = work_q >> 1;
  assign w_adjusted[BIN_W-1:0] = w_shifted[BIN_W-1:0];

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_adjust u_adjust (
        .nib_i (w_shifted [BIN_W + 4*i +: 4]),
        .nib_o (w_adjusted[BIN_W + 4*i +: 4])
      );
      assign w_nib_bad[i] = (bus.bcd_in[4*i +: 4] > 4'd9);
    end
  endgenerate

  assign w_any_bad = |w_nib_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      binary_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      binary_q <= binary_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    binary_d = binary_q;
    error_d  = error_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          work_d = {bus.bcd_in, {BIN_W{1'b0}}};
          cnt_d  = '0;
          if (w_any_bad) begin
            state_d  = ST_DONE;
            binary_d = '0;
            error_d  = 1'b1;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        work_d = w_adjusted;
        cnt_d  = cnt_q + c_one;
        if (cnt_q == c_last) begin
          state_d  = ST_DONE;
          binary_d = w_adjusted[BIN_W-1:0];
          error_d  = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.ready  = (state_q == ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.binary = binary_q;
  assign bus.error  = error_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_binary.sv
// ============================================================================
// Module   : tb_bcd_to_binary
// Purpose  : Directed self-checking bench for bcd_to_binary (3 digits, 10 bits).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_binary;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  bcd_to_binary_if #(.DIGITS(3), .BIN_W(10)) bus ();

  bcd_to_binary #(.DIGITS(3), .BIN_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!bus.ready && w < 40) begin
      tick();
      w++;
    end
    if (!bus.ready) check_eq("ready_timeout", 32'(bus.ready), 32'd1);
  endtask

  // Accepts one conversion, then scrambles bcd_in; returns edges from accept to done.
  task automatic run_conv(input logic [11:0] bcd, output int lat,
                          output logic [9:0] bin, output logic err);
    wait_ready();
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    tick();
    bus.start  = 1'b0;
    bus.bcd_in = 12'hFFF;
    lat = 0;
    while (!bus.done && lat < 50) begin
      tick();
      lat++;
    end
    if (!bus.done) check_eq("done_timeout", 32'(bus.done), 32'd1);
    bin = bus.binary;
    err = bus.error;
    tick();
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (bus.done) n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat, n, gap;
    logic [9:0] bin;
    logic       err;

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_ready",  32'(bus.ready),  32'd1);
    check_eq("rst_done",   32'(bus.done),   32'd0);
    check_eq("rst_error",  32'(bus.error),  32'd0);
    check_eq("rst_binary", 32'(bus.binary), 32'd0);
    check_eq("rst_cnt",    32'(dut.cnt_q),  32'd0);

    // Zero
    run_conv(12'h000, lat, bin, err);
    check_eq("zero_lat", 32'(lat), 32'd10);
    check_eq("zero_bin", 32'(bin), 32'd0);
    check_eq("zero_err", 32'(err), 32'd0);

    // Maximum, with one-cycle done and ready returning after it
    run_conv(12'h999, lat, bin, err);
    check_eq("max_lat", 32'(lat), 32'd10);
    check_eq("max_bin", 32'(bin), 32'd999);
    check_eq("max_err", 32'(err), 32'd0);
    check_eq("max_done_width", 32'(bus.done),  32'd0);
    check_eq("max_ready_back", 32'(bus.ready), 32'd1);

    run_conv(12'h255, lat, bin, err);
    check_eq("h255_bin", 32'(bin), 32'd255);

    // Invalid digit in middle, top and bottom nibbles
    run_conv(12'h1A3, lat, bin, err);
    check_eq("inv_lat", 32'(lat), 32'd0);
    check_eq("inv_err", 32'(err), 32'd1);
    check_eq("inv_bin", 32'(bin), 32'd0);
    check_eq("inv_done_width", 32'(bus.done), 32'd0);
    run_conv(12'hF99, lat, bin, err);
    check_eq("invF_lat", 32'(lat), 32'd0);
    check_eq("invF_err", 32'(err), 32'd1);
    run_conv(12'h00A, lat, bin, err);
    check_eq("invA_err", 32'(err), 32'd1);
    check_eq("invA_bin", 32'(bin), 32'd0);
    run_conv(12'h010, lat, bin, err);
    check_eq("after_inv_err", 32'(err), 32'd0);
    check_eq("after_inv_bin", 32'(bin), 32'd10);

    // Busy start ignored and not queued
    wait_ready();
    bus.start  = 1'b1;
    bus.bcd_in = 12'h042;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    bus.start  = 1'b1;
    bus.bcd_in = 12'h123;
    tick();
    bus.start = 1'b0;
    lat = 4;
    while (!bus.done && lat < 50) begin
      tick();
      lat++;
    end
    check_eq("busy_lat", 32'(lat), 32'd10);
    check_eq("busy_bin", 32'(bus.binary), 32'd42);
    count_dones(20, n);
    check_eq("busy_no_second_done", 32'(n), 32'd0);
    check_eq("busy_bin_held", 32'(bus.binary), 32'd42);

    // Reset mid-conversion
    wait_ready();
    bus.start  = 1'b1;
    bus.bcd_in = 12'h500;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst_ready",  32'(bus.ready),  32'd1);
    check_eq("midrst_binary", 32'(bus.binary), 32'd0);
    check_eq("midrst_done",   32'(bus.done),   32'd0);
    count_dones(15, n);
    check_eq("midrst_no_done", 32'(n), 32'd0);
    run_conv(12'h007, lat, bin, err);
    check_eq("post_rst_bin", 32'(bin), 32'd7);
    check_eq("post_rst_lat", 32'(lat), 32'd10);

    // Reset wins over start on the same edge
    reset      = 1'b1;
    bus.start  = 1'b1;
    bus.bcd_in = 12'h321;
    tick();
    reset     = 1'b0;
    bus.start = 1'b0;
    check_eq("rst_prio_ready", 32'(bus.ready), 32'd1);
    tick();
    check_eq("rst_prio_idle", 32'(bus.ready), 32'd1);

    // Back-to-back with start held high
    bus.start  = 1'b1;
    bus.bcd_in = 12'h123;
    n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    check_eq("b2b_first_bin", 32'(bus.binary), 32'd123);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!bus.done && gap < 40);
    check_eq("b2b_period", 32'(gap), 32'd12);
    check_eq("b2b_second_bin", 32'(bus.binary), 32'd123);
    bus.start = 1'b0;
    tick();

    // Full sweep against the bench encoder
    for (int v = 0; v < 1000; v++) begin
      run_conv(to_bcd(v), lat, bin, err);
      check_eq($sformatf("sweep_bin_%0d", v), 32'(bin), 32'(v));
      check_eq($sformatf("sweep_err_%0d", v), 32'(err), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_to_binary.md
BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 SHALL have parameter DIGITS, default 3: number of packed BCD input digits.
REQ-002 SHALL have parameter BIN_W, default 10: binary output width; SHALL satisfy 2^BIN_W > 10^DIGITS - 1.
REQ-003 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1: request a conversion; sampled only when ready=1.
REQ-006 SHALL have port bcd_in  input  4*DIGITS: packed BCD, most significant digit in the top nibble; sampled on the accepting edge only.
REQ-007 SHALL have port ready  output  1: high only in IDLE.
REQ-008 SHALL have port done  output  1: one-cycle pulse marking a completed conversion.
REQ-009 SHALL have port binary  output  BIN_W: converted value; valid from done high and held until the next done.
REQ-010 SHALL have port error  output  1: qualifies done; high when any input nibble exceeded 9.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-012 IDLE: ready=1; on start=1, SHALL latch bcd_in into the working register, clear the iteration counter and the binary shift field, and go to SHIFT; if any nibble is greater than 9, SHALL go to DONE with error pending instead.
REQ-013 SHIFT: each edge SHALL shift the {BCD, binary} working register right by one bit, then subtract 3 from every BCD nibble that is 8 or greater (reverse double-dabble); exactly BIN_W iterations, then DONE.
REQ-014 DONE: done=1 for exactly one cycle, binary registered from the shift field (or 0 if error), error=1 iff an invalid digit was seen; next edge SHALL go to IDLE.
REQ-015 Latency, valid input: done SHALL be high in the cycle after edge BIN_W following the accepting edge (10 cycles at default); ready SHALL return 1 one cycle later.
REQ-016 Latency, invalid input: done and error SHALL be high in the cycle after the accepting edge.
REQ-017 Busy behaviour: start while ready=0 (SHIFT or DONE) SHALL be ignored and SHALL NOT be queued.
REQ-018 Input stability: changes on bcd_in after the accepting edge SHALL NOT affect the result.
REQ-019 Error scope: error SHALL change only on the edge entering DONE.
REQ-020 Counter width: the iteration counter SHALL be clog2(BIN_W+1) bits and SHALL NOT wrap within a conversion.
REQ-021 Back-to-back: start asserted continuously SHALL yield one conversion per BIN_W+2 cycles.

Reset
REQ-022 With reset=1 at a rising edge, the FSM SHALL enter IDLE and ready=1, done=0, error=0, binary=0, counter=0 after that edge.
REQ-023 Reset mid-conversion SHALL abort with no done pulse, and reset SHALL take priority over start on the same edge.

Structure
REQ-024 The state encoding and the DIGITS/BIN_W defaults SHALL live in the shared package scoreboard_pkg.
REQ-025 The per-nibble "subtract 3 if 8 or greater" correction SHALL be a combinational sub-module bcd_digit_adjust, instantiated DIGITS times.
REQ-026 The datapath SHALL use one working register of 4*DIGITS+BIN_W bits with no multipliers.

Verification
REQ-027 Zero: bcd_in=12'h000 with start pulse -> done after 10 cycles, binary=0, error=0.
REQ-028 Maximum: bcd_in=12'h999 -> binary=10'd999 (0x3E7), error=0, done exactly one cycle wide.
REQ-029 Round trip: bcd_in=12'h255 -> binary=8'hFF zero-extended; sweep 0..999 against the scoreboard's binary-to-BCD encoder -> all values match.
REQ-030 Invalid digit: bcd_in=12'h1A3 -> done and error high on the cycle after accept, binary=0.
REQ-031 Busy start: start re-pulsed at cycle 4 with bcd_in=12'h123 during conversion of 12'h042 -> single done, binary=42, no second done.
REQ-032 Reset mid-conversion: reset at cycle 5 of conversion of 12'h500 -> no done, ready=1 and binary=0 next cycle; next conversion of 12'h007 gives 7.
